// File: rtl/ariane_pkg.sv
// Shared core types: functional-unit encodings, exception record and the
// scoreboard entry exchanged between issue, execute and commit.
package ariane_pkg;

    localparam int unsigned NR_SB_ENTRIES = 4;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
    localparam int unsigned NR_WB_PORTS   = 2;

    localparam logic [63:0] INSTR_ADDR_MISALIGNED = 64'd0;
    localparam logic [63:0] INSTR_ACCESS_FAULT    = 64'd1;
    localparam logic [63:0] ILLEGAL_INSTR         = 64'd2;
    localparam logic [63:0] BREAKPOINT            = 64'd3;

    typedef enum logic [2:0] {
        NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR
    } fu_t;

    typedef enum logic [3:0] {
        ADD, SUB, ANDL, ORL, XORL, SLL, SRL, SRA,
        LD, SD, JALR, MUL, CSR_RW
    } fu_op;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        fu_op                     op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        exception                 ex;
    } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// In-order issue / out-of-order writeback / in-order commit buffer.
// Pointers are TRANS_ID_BITS wide, so NR_ENTRIES must equal 2**TRANS_ID_BITS.
module scoreboard
    import ariane_pkg::scoreboard_entry;
    import ariane_pkg::exception;
    import ariane_pkg::TRANS_ID_BITS;
#(
    parameter int unsigned NR_ENTRIES  = ariane_pkg::NR_SB_ENTRIES,
    parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_i,
    output logic                                        full_o,
    input  scoreboard_entry                             decoded_instr_i,
    input  logic                                        decoded_instr_valid_i,
    output logic                                        decoded_instr_ack_o,
    output logic [TRANS_ID_BITS-1:0]                    issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]                wdata_i,
    input  exception [NR_WB_PORTS-1:0]                  ex_i,
    output scoreboard_entry                             commit_instr_o,
    output logic                                        commit_valid_o,
    input  logic                                        commit_ack_i,
    output logic [31:0]                                 rd_clobber_o
);

    localparam int unsigned PW = TRANS_ID_BITS;

    typedef struct packed {
        logic            occupied;
        scoreboard_entry sbe;
    } slot_t;

    slot_t            mem_q [NR_ENTRIES];
    slot_t            mem_d [NR_ENTRIES];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             commit_fire;

    assign full_o              = (cnt_q == (PW+1)'(NR_ENTRIES));
    assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
    assign issue_trans_id_o    = tail_q;
    assign commit_instr_o      = mem_q[head_q].sbe;
    assign commit_valid_o      = mem_q[head_q].occupied & mem_q[head_q].sbe.valid;
    assign commit_fire         = commit_valid_o & commit_ack_i;

    // Writes are applied lowest priority first so later statements win:
    // writeback, then commit-clear / issue-write, then flush.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;

        for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
            if (wb_valid_i[p] && mem_q[trans_id_i[p]].occupied &&
                !(commit_fire && (trans_id_i[p] == head_q))) begin
                mem_d[trans_id_i[p]].sbe.result = wdata_i[p];
                mem_d[trans_id_i[p]].sbe.valid  = 1'b1;
                if (ex_i[p].valid) begin
                    mem_d[trans_id_i[p]].sbe.ex = ex_i[p];
                end
            end
        end

        if (commit_fire) begin
            mem_d[head_q].occupied = 1'b0;
            head_d = head_q + PW'(1);
        end

        if (decoded_instr_ack_o) begin
            mem_d[tail_q].sbe          = decoded_instr_i;
            mem_d[tail_q].sbe.trans_id = tail_q;
            mem_d[tail_q].sbe.valid    = 1'b0;
            mem_d[tail_q].occupied     = 1'b1;
            tail_d = tail_q + PW'(1);
        end

        cnt_d = cnt_q + (PW+1)'(decoded_instr_ack_o) - (PW+1)'(commit_fire);

        if (flush_i) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_d[i].occupied = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    always_comb begin
        rd_clobber_o = '0;
        for (int i = 0; i < int'(NR_ENTRIES); i++) begin
            if (mem_q[i].occupied) begin
                rd_clobber_o[mem_q[i].sbe.rd] = 1'b1;
            end
        end
        rd_clobber_o[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench: stimulus pushes expected commit records into a queue and a
// separate monitor pops and compares them whenever a commit is accepted.
module tb_scoreboard;
    import ariane_pkg::*;

    logic                                   clk;
    logic                                   rst;
    logic                                   flush;
    logic                                   full;
    scoreboard_entry                        dec_instr;
    logic                                   dec_valid;
    logic                                   dec_ack;
    logic [TRANS_ID_BITS-1:0]               issue_id;
    logic [NR_WB_PORTS-1:0]                 wb_valid;
    logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_id;
    logic [NR_WB_PORTS-1:0][63:0]           wb_data;
    exception [NR_WB_PORTS-1:0]             wb_ex;
    scoreboard_entry                        commit_instr;
    logic                                   commit_valid;
    logic                                   commit_ack;
    logic [31:0]                            clobber;

    typedef struct {
        logic [TRANS_ID_BITS-1:0] id;
        logic [4:0]               rd;
        logic [63:0]              res;
        logic                     exv;
        logic [63:0]              cause;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    scoreboard dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .flush_i               (flush),
        .full_o                (full),
        .decoded_instr_i       (dec_instr),
        .decoded_instr_valid_i (dec_valid),
        .decoded_instr_ack_o   (dec_ack),
        .issue_trans_id_o      (issue_id),
        .wb_valid_i            (wb_valid),
        .trans_id_i            (wb_id),
        .wdata_i               (wb_data),
        .ex_i                  (wb_ex),
        .commit_instr_o        (commit_instr),
        .commit_valid_o        (commit_valid),
        .commit_ack_i          (commit_ack),
        .rd_clobber_o          (clobber)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Garbage in trans_id/valid checks that issue overwrites them.
    function automatic scoreboard_entry mk(input logic [4:0] rd);
        scoreboard_entry e;
        e          = '0;
        e.pc       = 64'h1000 + 64'(rd) * 4;
        e.fu       = ALU;
        e.op       = ADD;
        e.rs1      = rd;
        e.rd       = rd;
        e.result   = 64'(rd) * 16;
        e.trans_id = '1;
        e.valid    = 1'b1;
        return e;
    endfunction

    // Monitor: pops one expected record per accepted commit.
    always @(negedge clk) begin
        if (!rst && commit_valid && commit_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("commit id=%0d rd=%0d result=0x%0h ex=%0d cause=%0d",
                         commit_instr.trans_id, commit_instr.rd, commit_instr.result,
                         commit_instr.ex.valid, commit_instr.ex.cause);
                chk("commit_id", 64'(commit_instr.trans_id), 64'(e.id));
                chk("commit_rd", 64'(commit_instr.rd), 64'(e.rd));
                chk("commit_result", commit_instr.result, e.res);
                chk("commit_ex_valid", 64'(commit_instr.ex.valid), 64'(e.exv));
                chk("commit_ex_cause", commit_instr.ex.cause, e.cause);
            end
        end
    end

    task automatic issue(input logic [4:0] rd, input bit want_ack, input logic [1:0] want_id,
                         input logic [63:0] want_res, input logic want_exv);
        dec_instr = mk(rd);
        dec_valid = 1'b1;
        @(negedge clk);
        $display("issue rd=%0d ack=%0d id=%0d", rd, dec_ack, issue_id);
        chk("issue_ack", 64'(dec_ack), 64'(want_ack));
        if (want_ack) begin
            chk("issue_id", 64'(issue_id), 64'(want_id));
            exp_q.push_back('{want_id, rd, want_res, want_exv,
                              want_exv ? ILLEGAL_INSTR : 64'd0});
        end
        @(posedge clk); #1;
        dec_valid = 1'b0;
    endtask

    task automatic wb(input int port, input logic [1:0] id, input logic [63:0] data,
                      input logic exv);
        wb_valid[port] = 1'b1;
        wb_id[port]    = id;
        wb_data[port]  = data;
        wb_ex[port]    = exv ? '{cause: ILLEGAL_INSTR, tval: 64'd0, valid: 1'b1} : '0;
        $display("wb port=%0d id=%0d data=0x%0h ex=%0d", port, id, data, exv);
        @(posedge clk); #1;
        wb_valid = '0;
    endtask

    task automatic commit();
        commit_ack = 1'b1;
        @(negedge clk);
        chk("commit_valid", 64'(commit_valid), 64'd1);
        @(posedge clk); #1;
        commit_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_instr = '0;
        wb_valid = '0; wb_id = '0; wb_data = '0; wb_ex = '0; commit_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 dec_valid = 1'b1;
        @(negedge clk);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_commit_valid", 64'(commit_valid), 64'd0);
        chk("reset_clobber", 64'(clobber), 64'd0);
        chk("reset_issue_id", 64'(issue_id), 64'd0);
        chk("reset_ack_follows_valid", 64'(dec_ack), 64'd1);
        dec_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill: ids 0..3, results hand-picked for the out-of-order writebacks below.
        issue(5'd1, 1, 2'd0, 64'hB, 1'b0);
        issue(5'd2, 1, 2'd1, 64'hC, 1'b0);
        issue(5'd3, 1, 2'd2, 64'hA, 1'b0);
        issue(5'd4, 1, 2'd3, 64'h33, 1'b0);
        @(negedge clk);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_clobber", 64'(clobber), 64'h1E);
        chk("fill_commit_valid", 64'(commit_valid), 64'd0);
        @(posedge clk); #1;
        issue(5'd9, 0, 2'd0, 64'd0, 1'b0);

        // Out-of-order writeback; head becomes committable only once id 0 lands.
        wb(0, 2'd2, 64'hA, 1'b0);
        @(negedge clk);
        chk("ooo_cv_after_id2", 64'(commit_valid), 64'd0);
        @(posedge clk); #1;
        wb(1, 2'd0, 64'hB, 1'b0);
        @(negedge clk);
        chk("ooo_cv_after_id0", 64'(commit_valid), 64'd1);
        @(posedge clk); #1;
        wb(0, 2'd1, 64'hC, 1'b0);
        commit();
        commit();
        commit();
        @(negedge clk);
        chk("drain_clobber", 64'(clobber), 64'h10);
        chk("drain_full", 64'(full), 64'd0);
        @(posedge clk); #1;

        // Tail wraps to 0: refill to full.
        issue(5'd5, 1, 2'd0, 64'h44, 1'b1);
        issue(5'd6, 1, 2'd1, 64'h22, 1'b0);
        issue(5'd7, 1, 2'd2, 64'd0, 1'b0);
        @(negedge clk);
        chk("refill_full", 64'(full), 64'd1);
        @(posedge clk); #1;
        wb(1, 2'd3, 64'h33, 1'b0);

        // Both ports hit id 1: port 1 must win.
        wb_valid = 2'b11;
        wb_id[0] = 2'd1; wb_data[0] = 64'h11; wb_ex[0] = '0;
        wb_id[1] = 2'd1; wb_data[1] = 64'h22; wb_ex[1] = '0;
        $display("wb conflict id=1 p0=0x11 p1=0x22");
        @(posedge clk); #1;
        wb_valid = '0;
        wb(0, 2'd0, 64'h44, 1'b1);

        // Full with head valid: commit and issue together, issue must wait a cycle.
        commit_ack = 1'b1;
        dec_instr  = mk(5'd8);
        dec_valid  = 1'b1;
        @(negedge clk);
        chk("full_commit_valid", 64'(commit_valid), 64'd1);
        chk("full_issue_blocked", 64'(dec_ack), 64'd0);
        @(posedge clk); #1;
        commit_ack = 1'b0;
        @(negedge clk);
        $display("issue rd=8 ack=%0d id=%0d", dec_ack, issue_id);
        chk("retry_issue_ack", 64'(dec_ack), 64'd1);
        chk("retry_issue_id", 64'(issue_id), 64'd3);
        exp_q.push_back('{2'd3, 5'd8, 64'd0, 1'b0, 64'd0});
        @(posedge clk); #1;
        dec_valid = 1'b0;
        commit();
        commit();
        issue(5'd9, 1, 2'd0, 64'd0, 1'b0);

        // Flush with 3 pending plus a concurrent issue and writeback.
        flush      = 1'b1;
        dec_instr  = mk(5'd12);
        dec_valid  = 1'b1;
        wb_valid   = 2'b01;
        wb_id[0]   = 2'd2; wb_data[0] = 64'h99; wb_ex[0] = '0;
        @(negedge clk);
        $display("flush ack=%0d", dec_ack);
        chk("flush_no_ack", 64'(dec_ack), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; dec_valid = 1'b0; wb_valid = '0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_full", 64'(full), 64'd0);
        chk("flush_commit_valid", 64'(commit_valid), 64'd0);
        chk("flush_clobber", 64'(clobber), 64'd0);
        chk("flush_issue_id", 64'(issue_id), 64'd0);
        @(posedge clk); #1;
        issue(5'd10, 1, 2'd0, 64'h77, 1'b0);
        wb(0, 2'd0, 64'h77, 1'b0);
        commit();

        // Commit ack with nothing committable is ignored.
        commit_ack = 1'b1;
        @(negedge clk);
        chk("idle_commit_valid", 64'(commit_valid), 64'd0);
        @(posedge clk); #1;
        commit_ack = 1'b0;
        issue(5'd11, 1, 2'd1, 64'd0, 1'b0);

        // Reset mid-operation overrides concurrent issue and writeback.
        rst       = 1'b1;
        dec_instr = mk(5'd13);
        dec_valid = 1'b1;
        wb_valid  = 2'b01;
        wb_id[0]  = 2'd1; wb_data[0] = 64'h5; wb_ex[0] = '0;
        @(posedge clk); #1;
        dec_valid = 1'b0; wb_valid = '0;
        exp_q.delete();
        @(negedge clk);
        $display("mid-op reset applied");
        chk("rst_issue_id", 64'(issue_id), 64'd0);
        chk("rst_clobber", 64'(clobber), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scoreboard.md
# scoreboard

In-order issue / out-of-order writeback / in-order commit buffer between the issue stage and the commit stage. It allocates one `scoreboard_entry` per issued instruction, tagged with a `trans_id`. It accepts results from the functional units on `NR_WB_PORTS` writeback ports and presents the oldest entry to commit once its result is valid.

## Interface
- `NR_ENTRIES`, default `ariane_pkg::NR_SB_ENTRIES` (4): entry count. Must be a power of two.
- `NR_WB_PORTS`, default `ariane_pkg::NR_WB_PORTS` (2): number of writeback ports.
- `clk_i` in, 1: clock.
- `rst_i` in, 1: reset; synchronous, active-high.
- `flush_i` in, 1: discard all entries.
- `full_o` out, 1: all entries occupied.
- `decoded_instr_i` in, `scoreboard_entry`: instruction to issue. Its `result` field carries the immediate.
- `decoded_instr_valid_i` in, 1: issue request.
- `decoded_instr_ack_o` out, 1: issue accepted this cycle.
- `issue_trans_id_o` out, `TRANS_ID_BITS`: id assigned to the accepted instruction (equals the tail pointer).
- `wb_valid_i` in, `NR_WB_PORTS`: per-port writeback strobe.
- `trans_id_i` in, `NR_WB_PORTS` x `TRANS_ID_BITS`: target entry.
- `wdata_i` in, `NR_WB_PORTS` x 64: result.
- `ex_i` in, `NR_WB_PORTS` x `exception`: exception raised by the unit.
- `commit_instr_o` out, `scoreboard_entry`: head entry.
- `commit_valid_o` out, 1: head is occupied and its result is valid.
- `commit_ack_i` in, 1: commit consumes the head.
- `rd_clobber_o` out, 32: bit r is set when an occupied entry has `rd == r`. Bit 0 is always 0.

## Operation
- State:
  - circular array of `NR_ENTRIES` entries, each with an `occupied` flag;
  - `head` and `tail` pointers, `TRANS_ID_BITS` wide;
  - `count`, `TRANS_ID_BITS+1` wide.
- `full_o = (count == NR_ENTRIES)`. It is derived from registered state; a commit in the same cycle does not free space for that cycle's issue.
- Issue:
  - `decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i`.
  - On ack, the entry at `tail` is written as follows:
    - fields copied from `decoded_instr_i`;
    - `trans_id` overwritten with `tail`;
    - `valid` = 0;
    - `ex.valid` kept from input (a decode exception);
    - `occupied` = 1.
  - `tail` increments modulo `NR_ENTRIES`.
- Writeback, for each port p with `wb_valid_i[p]` whose target entry is occupied:
  - `result <= wdata_i[p]` and `valid <= 1`;
  - if `ex_i[p].valid`, `ex <= ex_i[p]`; otherwise `ex` is unchanged.
  - Writeback to an unoccupied entry is ignored.
  - Two ports targeting the same id in one cycle: the higher port index wins.
- Commit:
  - `commit_instr_o` is combinational from `entry[head]`.
  - `commit_valid_o = entry[head].occupied & entry[head].valid`.
  - `commit_valid_o & commit_ack_i`: clear `occupied` and increment `head`. `commit_ack_i` without `commit_valid_o` is ignored.
- `count` next value = `count` + issue accepted − commit accepted. Simultaneous issue and commit leaves `count` unchanged.
- Flush (priority over everything except reset):
  - all `occupied` cleared;
  - `head = tail = count = 0`;
  - writebacks and commit in the same cycle have no effect;
  - no issue is accepted.
- `rd_clobber_o` is the OR over occupied entries of the one-hot decode of `rd`, with bit 0 forced to 0. It is combinational from registered state.

## Timing
- Reset, and state after a flush:
  - `head = tail = count = 0`, all entries unoccupied;
  - `full_o = 0`, `commit_valid_o = 0`, `rd_clobber_o = 0`, `issue_trans_id_o = 0`;
  - `decoded_instr_ack_o` follows `decoded_instr_valid_i & ~flush_i`.
- Issue in cycle n makes the entry visible in cycle n+1. Writeback in cycle n+1 at the earliest; `commit_valid_o` at n+2 at the earliest. There is no same-cycle writeback-to-commit bypass.
- A writeback to `head` in the same cycle as an ack of `head` targets the freed slot and is dropped.
- A writeback to `head` while `commit_valid_o = 0` sets `commit_valid_o` from the next cycle.
- Wrap-around: the pointers wrap naturally because `NR_ENTRIES` is a power of two. Full versus empty is distinguished by `count` alone.
- Reset asserted mid-operation: the next edge produces the reset state, regardless of `flush_i`, issue or writeback inputs.

## Structure
- `scoreboard_entry`, `exception`, `fu_t`, `fu_op`, `NR_SB_ENTRIES`, `TRANS_ID_BITS` and `NR_WB_PORTS` stay in `ariane_pkg`. No new package types are needed.
- Single module, no sub-module. Use a flat entry array with an explicit priority order for writes: reset > flush > commit-clear / issue-write > writeback.

## Test plan
- **Fill and drain:** after reset, issue 4 instructions with rd = 1,2,3,4.
  - `issue_trans_id_o` = 0,1,2,3; `full_o` = 1; 5th request gets no ack; `rd_clobber_o` = 0x1E.
- **Out-of-order writeback:** write ids 2,0,1 with data 0xA,0xB,0xC.
  - `commit_valid_o` rises only after id 0 is written; commits then emit results 0xB, 0xC, 0xA in order.
- **Writeback port conflict:** ports 0 and 1 both write id 1 in the same cycle with 0x11 and 0x22.
  - Entry 1 result = 0x22.
- **Writeback exception:** port 0 writes id 0 with `ex.valid = 1` and `cause = ILLEGAL_INSTR`.
  - At commit, `commit_instr_o.ex.cause` = 2 and `ex.valid` = 1.
- **Full with simultaneous commit and issue:** full buffer, head valid; `commit_ack_i` and issue request in the same cycle.
  - Commit happens, issue gets no ack; the next cycle the issue is accepted with id = old head.
- **Flush:** with 3 entries pending, assert `flush_i` together with an issue and a writeback.
  - Next cycle: `count` = 0, `commit_valid_o` = 0, `rd_clobber_o` = 0; the next issue receives id 0.
